// File: rtl/filterbank_scheduler_pkg.sv
// Shared constants for the filterbank scheduler and anything that consumes its outputs.
// fb_m packing: upstream meta in the MSBs, filter index in the LSBs.
package filterbank_scheduler_pkg;

  localparam int unsigned ErrOvf   = 0;
  localparam int unsigned ErrAlign = 1;
  localparam int unsigned ErrFb    = 2;
  localparam int unsigned NumErr   = 3;

endpackage

// File: rtl/fb_sample_fifo.sv
// Synchronous FIFO with show-ahead head output; simultaneous read and write allowed,
// including a write while full when a read happens in the same cycle.
module fb_sample_fifo #(
  parameter int unsigned Width    = 33,
  parameter int unsigned Depth    = 4,
  parameter int unsigned LogDepth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0]  mem_q [Depth];
  logic [LogDepth:0] wr_ptr_q, rd_ptr_q;
  logic              do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LogDepth] != rd_ptr_q[LogDepth]) &&
                   (wr_ptr_q[LogDepth-1:0] == rd_ptr_q[LogDepth-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q[LogDepth-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[LogDepth-1:0]] <= wr_data;
  end

endmodule

// File: rtl/filterbank_scheduler.sv
// Buffers upstream samples and issues them to the filterbank at most once every GAP cycles,
// tagging each with its filter index; monitors filterbank outputs for index alignment.
module filterbank_scheduler
  import filterbank_scheduler_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned LOG_N      = 3,
  parameter int unsigned WDTH       = 32,
  parameter int unsigned MWDTH      = 1,
  parameter int unsigned GAP        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOG_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WDTH-1:0]        in_data,
  input  logic                   in_nd,
  input  logic [MWDTH-1:0]       in_m,
  input  logic                   enable,
  output logic [WDTH-1:0]        fb_data,
  output logic                   fb_nd,
  output logic [MWDTH+LOG_N-1:0] fb_m,
  input  logic                   fb_out_nd,
  input  logic                   fb_first_filter,
  input  logic                   fb_error,
  output logic                   frame_done,
  output logic [2:0]             err_flags,
  output logic                   error
);

  localparam int unsigned FifoW = MWDTH + WDTH;
  localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;

  logic                   pop, wr_en, full, empty;
  logic [FifoW-1:0]       head;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [LOG_N-1:0]       issue_idx_q, out_idx_q;
  logic [WDTH-1:0]        fb_data_q;
  logic                   fb_nd_q, frame_done_q, error_q;
  logic [MWDTH+LOG_N-1:0] fb_m_q;
  logic [NumErr-1:0]      err_q, err_d;

  assign pop   = enable && !empty && (gap_q == '0);
  assign wr_en = in_nd && (!full || pop);

  fb_sample_fifo #(
    .Width    (FifoW),
    .Depth    (FIFO_DEPTH),
    .LogDepth (LOG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({in_m, in_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Gap counter keeps running while enable is low so re-enabling never shortens the spacing.
  always_comb begin
    gap_d = gap_q;
    if (pop) begin
      gap_d = GapW'(GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (in_nd && full && !pop) err_d[ErrOvf] = 1'b1;
    if (fb_out_nd && (fb_first_filter != (out_idx_q == '0))) err_d[ErrAlign] = 1'b1;
    if (fb_error) err_d[ErrFb] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q        <= '0;
      issue_idx_q  <= '0;
      out_idx_q    <= '0;
      fb_data_q    <= '0;
      fb_nd_q      <= 1'b0;
      fb_m_q       <= '0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
      error_q      <= 1'b0;
    end else begin
      gap_q        <= gap_d;
      err_q        <= err_d;
      error_q      <= |err_q;
      fb_nd_q      <= pop;
      frame_done_q <= fb_out_nd && (out_idx_q == LOG_N'(N - 1));
      if (pop) begin
        fb_data_q   <= head[WDTH-1:0];
        fb_m_q      <= {head[FifoW-1:WDTH], issue_idx_q};
        issue_idx_q <= issue_idx_q + LOG_N'(1);
      end
      // No resync on misalignment: the index keeps counting so the error stays visible.
      if (fb_out_nd) out_idx_q <= out_idx_q + LOG_N'(1);
    end
  end

  assign fb_data    = fb_data_q;
  assign fb_nd      = fb_nd_q;
  assign fb_m       = fb_m_q;
  assign frame_done = frame_done_q;
  assign err_flags  = err_q;
  assign error      = error_q;

endmodule

// File: tb/tb_filterbank_scheduler.sv
// Directed bench for filterbank_scheduler: issue order, spacing, overflow, alignment monitor,
// sticky errors, mid-stream reset, and a constrained random stream against a queue model.
module tb_filterbank_scheduler;

  localparam int N = 8, LOG_N = 3, WDTH = 32, MWDTH = 1, GAP = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [WDTH-1:0]        in_data = '0;
  logic                   in_nd = 1'b0;
  logic [MWDTH-1:0]       in_m = '0;
  logic                   enable = 1'b0;
  logic [WDTH-1:0]        fb_data;
  logic                   fb_nd;
  logic [MWDTH+LOG_N-1:0] fb_m;
  logic                   fb_out_nd = 1'b0;
  logic                   fb_first_filter = 1'b0;
  logic                   fb_error = 1'b0;
  logic                   frame_done;
  logic [2:0]             err_flags;
  logic                   error;

  filterbank_scheduler #(
    .N          (N),
    .LOG_N      (LOG_N),
    .WDTH       (WDTH),
    .MWDTH      (MWDTH),
    .GAP        (GAP),
    .FIFO_DEPTH (4),
    .LOG_DEPTH  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_nd           (in_nd),
    .in_m            (in_m),
    .enable          (enable),
    .fb_data         (fb_data),
    .fb_nd           (fb_nd),
    .fb_m            (fb_m),
    .fb_out_nd       (fb_out_nd),
    .fb_first_filter (fb_first_filter),
    .fb_error        (fb_error),
    .frame_done      (frame_done),
    .err_flags       (err_flags),
    .error           (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] cap_data[$];
  logic [3:0]  cap_m[$];
  int          cap_cyc[$];

  always @(negedge clk) begin
    if (fb_nd) begin
      cap_data.push_back(fb_data);
      cap_m.push_back(fb_m);
      cap_cyc.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_m.delete();
    cap_cyc.delete();
  endtask

  // All tasks start and end just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    in_nd = 1'b0; fb_out_nd = 1'b0; fb_error = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_cap();
  endtask

  task automatic push_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_nd   = 1'b1;
      in_data = WDTH'(base + i);
      in_m    = MWDTH'(i & 1);
      @(negedge clk);
    end
    in_nd = 1'b0;
  endtask

  function automatic logic [3:0] exp_m(input int meta, input int idx);
    return {meta[0], idx[2:0]};
  endfunction

  int k, m, min_gap, pushed, cnt;
  int sel[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11};
  logic [31:0] exp_d[$];
  logic [3:0]  exp_mq[$];
  logic [31:0] rd;
  logic        rm;

  initial begin
    @(negedge clk);
    do_reset();
    check("reset fb_nd", fb_nd, 0);
    check("reset fb_data", fb_data, 0);
    check("reset fb_m", fb_m, 0);
    check("reset err_flags", err_flags, 0);
    check("reset error", error, 0);
    check("reset frame_done", frame_done, 0);

    // 1: eight back-to-back samples, spaced issues with running index
    enable = 1'b1;
    k = cyc;
    push_burst(8, 100);
    step(20);
    check("t1 count", cap_data.size(), 8);
    if (cap_cyc.size() > 0) check("t1 first latency", cap_cyc[0], k + 2);
    for (int i = 0; i < cap_data.size() && i < 8; i++) begin
      check($sformatf("t1 data%0d", i), cap_data[i], 100 + i);
      check($sformatf("t1 m%0d", i), cap_m[i], exp_m(i & 1, i));
      if (i > 0) check($sformatf("t1 spacing%0d", i), cap_cyc[i] - cap_cyc[i-1], GAP);
    end
    check("t1 err", err_flags, 0);

    // 2: seven fit, twelve overflow and drop samples 8 and 10
    do_reset();
    push_burst(7, 200);
    step(20);
    check("t2a count", cap_data.size(), 7);
    check("t2a err", err_flags, 0);
    clear_cap();
    push_burst(12, 220);
    step(30);
    check("t2b err", err_flags, 3'b001);
    check("t2b error", error, 1);
    check("t2b count", cap_data.size(), 10);
    for (int i = 0; i < cap_data.size() && i < 10; i++) begin
      check($sformatf("t2b data%0d", i), cap_data[i], 220 + sel[i]);
      check($sformatf("t2b m%0d", i), cap_m[i], exp_m(sel[i] & 1, 7 + i));
    end

    // 3: hold while filling, then pop and write together while full
    do_reset();
    enable = 1'b0;
    push_burst(4, 300);
    step(6);
    check("t3 held count", cap_data.size(), 0);
    enable = 1'b1;
    in_nd = 1'b1; in_data = 304; in_m = 0;
    @(negedge clk);
    in_nd = 1'b0;
    step(15);
    check("t3 err", err_flags, 0);
    check("t3 count", cap_data.size(), 5);
    for (int i = 0; i < cap_data.size() && i < 5; i++)
      check($sformatf("t3 data%0d", i), cap_data[i], 300 + i);

    // 4: aligned output stream, then misaligned
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fb_out_nd = 1'b1;
      fb_first_filter = (i == 0 || i == 8);
      @(negedge clk);
      check($sformatf("t4 frame_done%0d", i), frame_done, (i == 7 || i == 15));
    end
    fb_out_nd = 1'b0; fb_first_filter = 1'b0;
    step(1);
    check("t4 aligned err", err_flags, 0);
    for (int j = 0; j < 3; j++) begin
      fb_out_nd = 1'b1;
      fb_first_filter = (j == 0 || j == 2);
      @(negedge clk);
      if (j == 1) check("t4 before misalign", err_flags, 0);
    end
    fb_out_nd = 1'b0; fb_first_filter = 1'b0;
    check("t4 misalign", err_flags, 3'b010);

    // 5: sticky fb_error, registered error, mid-stream reset
    do_reset();
    fb_error = 1'b1;
    @(negedge clk);
    fb_error = 1'b0;
    check("t5 err set", err_flags, 3'b100);
    check("t5 error lag", error, 0);
    @(negedge clk);
    check("t5 error", error, 1);
    step(5);
    check("t5 err sticky", err_flags, 3'b100);
    check("t5 error sticky", error, 1);
    enable = 1'b1;
    push_burst(4, 400);
    step(1);
    check("t5 pre-rst count", cap_data.size(), 2);
    if (cap_m.size() > 1) check("t5 pre-rst m1", cap_m[1], exp_m(1, 1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 rst fb_nd", fb_nd, 0);
    check("t5 rst fb_data", fb_data, 0);
    check("t5 rst fb_m", fb_m, 0);
    check("t5 rst err", err_flags, 0);
    check("t5 rst error", error, 0);
    check("t5 rst frame_done", frame_done, 0);
    clear_cap();
    step(10);
    check("t5 discarded", cap_data.size(), 0);
    push_burst(1, 500);
    step(5);
    check("t5 post count", cap_data.size(), 1);
    if (cap_data.size() > 0) begin
      check("t5 post data", cap_data[0], 500);
      check("t5 post idx", cap_m[0], exp_m(0, 0));
    end

    // 6: random stream, throttled so the FIFO never overflows
    do_reset();
    pushed = 0;
    cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ((pushed - cap_data.size()) < 3 && $urandom_range(0, 1) == 1) begin
        rd = $urandom;
        rm = 1'(($urandom >> 3) & 1);
        in_nd = 1'b1; in_data = rd; in_m = rm;
        exp_d.push_back(rd);
        exp_mq.push_back({rm, 3'(pushed)});
        pushed++;
      end else begin
        in_nd = 1'b0;
      end
      @(negedge clk);
    end
    in_nd = 1'b0;
    enable = 1'b1;
    step(20);
    check("t6 count", cap_data.size(), exp_d.size());
    check("t6 err", err_flags, 0);
    m = 0;
    min_gap = 1000;
    for (int i = 0; i < cap_data.size() && i < exp_d.size(); i++) begin
      if (cap_data[i] !== exp_d[i] || cap_m[i] !== exp_mq[i]) begin
        m++;
        if (m <= 4)
          $display("FAIL t6 item%0d: got %0h/%0h, expected %0h/%0h",
                   i, cap_data[i], cap_m[i], exp_d[i], exp_mq[i]);
      end
      if (i > 0 && (cap_cyc[i] - cap_cyc[i-1]) < min_gap) min_gap = cap_cyc[i] - cap_cyc[i-1];
    end
    check("t6 stream miscompares", m, 0);
    check("t6 min gap ok", (min_gap >= GAP), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
